// File: rtl/cpu6_bus_responder_if.sv
// CPU6 bus plus console stream signals seen by the responder.
// Latency: n/a (wiring only).
// Backpressure: tx uses tx_valid/tx_ready, rx uses rx_valid/rx_ready.
//
// Signals:
//   address_bus, data_out_bus, write_en_bus, read_strobe : CPU -> responder
//   data_in_bus                                           : responder -> CPU
//   tx_data, tx_valid / tx_ready                          : console byte to host
//   rx_data, rx_valid / rx_ready                          : console byte from host
//
// The master modport is the CPU/host side and the slave modport is the responder.
interface cpu6_bus_responder_if;
  logic [15:0] address_bus;
  logic [7:0]  data_out_bus;
  logic        write_en_bus;
  logic        read_strobe;
  logic [7:0]  data_in_bus;

  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  modport master (
    output address_bus, data_out_bus, write_en_bus, read_strobe,
    input  data_in_bus,
    input  tx_data, tx_valid,
    output tx_ready,
    output rx_data, rx_valid,
    input  rx_ready
  );

  modport slave (
    input  address_bus, data_out_bus, write_en_bus, read_strobe,
    output data_in_bus,
    output tx_data, tx_valid,
    input  tx_ready,
    input  rx_data, rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/cpu6_bus_responder.sv
// CPU6 target responder: on-chip RAM plus a console MMIO window (TX FIFO and RX holding register).
// Latency: read data is registered, so data_in_bus reflects the address presented one clock earlier.
// Backpressure: host stalls the TX FIFO through tx_ready, and full-FIFO writes are dropped and set a sticky overflow flag.
//
// Ports:
//   clock    : system clock, rising edge
//   reset    : asynchronous, active-high
//   bus      : slave modport of cpu6_bus_responder_if (CPU bus and console streams)
//
// Memory map:
//   0x0000 .. 2^RAM_ADDR_BITS-1 : RAM
//   MMIO_BASE                   : STATUS  {5'b0, overflow, ~fifo_full, rx_full}
//                                 A write to STATUS clears overflow.
//   MMIO_BASE+1                 : DATA
//                                 A write pushes to TX. A read returns rx_hold, and read_strobe releases it.
//   anything else               : reads 0xFF, writes ignored
module cpu6_bus_responder #(
  parameter int          RAM_ADDR_BITS   = 12,
  parameter logic [15:0] MMIO_BASE       = 16'hF200,
  parameter int          FIFO_DEPTH_LOG2 = 2
) (
  input logic                  clock,
  input logic                  reset,
  cpu6_bus_responder_if.slave  bus
);

  localparam int          RAM_SIZE   = 1 << RAM_ADDR_BITS;
  localparam logic [16:0] RAM_LIMIT  = 17'(RAM_SIZE);
  localparam logic [15:0] STATUS_ADR = MMIO_BASE;
  localparam logic [15:0] DATA_ADR   = MMIO_BASE + 16'd1;
  localparam int          DEPTH      = 1 << FIFO_DEPTH_LOG2;
  localparam int          CW         = FIFO_DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic is_ram;
  logic is_status;
  logic is_data;

  assign is_ram    = ({1'b0, bus.address_bus} < RAM_LIMIT);
  assign is_status = (bus.address_bus == STATUS_ADR);
  assign is_data   = (bus.address_bus == DATA_ADR);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // RAM has no reset so that it maps onto block RAM and survives a reset pulse.
  logic [7:0]                 ram [0:RAM_SIZE-1];
  logic [7:0]                 tx_fifo [0:DEPTH-1];
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [CW-1:0]              count;
  logic                       overflow;
  logic                       rx_full;
  logic [7:0]                 rx_hold;
  logic [7:0]                 data_in_q;

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  logic fifo_full;
  logic fifo_empty;
  logic data_wr;
  logic push;
  logic pop;
  logic overflow_set;
  logic overflow_clr;

  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  assign data_wr    = bus.write_en_bus && is_data;

  // Fullness is judged before any pop in the same cycle, so a write to a full FIFO is dropped even while the host drains it.
  assign push         = data_wr && !fifo_full;
  assign overflow_set = data_wr && fifo_full;
  assign overflow_clr = bus.write_en_bus && is_status;
  assign pop          = !fifo_empty && bus.tx_ready;

  // ---------------------------------------------------------------------------
  // RX control
  // ---------------------------------------------------------------------------
  logic rx_accept;
  logic rx_release;

  assign rx_accept  = bus.rx_valid && !rx_full;
  // A strobe while empty reads stale rx_hold and changes nothing.
  assign rx_release = bus.read_strobe && is_data && rx_full;

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic [7:0] rd_value;

  always_comb begin
    rd_value = 8'hFF;
    if (is_ram) begin
      rd_value = ram[bus.address_bus[RAM_ADDR_BITS-1:0]];
    end else if (is_status) begin
      rd_value = {5'b0, overflow, ~fifo_full, rx_full};
    end else if (is_data) begin
      rd_value = rx_hold;
    end
  end

  // ---------------------------------------------------------------------------
  // RAM write port
  // ---------------------------------------------------------------------------
  // The read register samples ram[] in the same edge, so a same-address write returns the old byte.
  always_ff @(posedge clock) begin
    if (bus.write_en_bus && is_ram) begin
      ram[bus.address_bus[RAM_ADDR_BITS-1:0]] <= bus.data_out_bus;
    end
  end

  // ---------------------------------------------------------------------------
  // Read data register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_in_q <= 8'h00;
    end else begin
      data_in_q <= rd_value;
    end
  end

  // ---------------------------------------------------------------------------
  // TX FIFO storage
  // ---------------------------------------------------------------------------
  // Entries are not reset, because only slots between the pointers are ever observed.
  always_ff @(posedge clock) begin
    if (push) begin
      tx_fifo[wr_ptr] <= bus.data_out_bus;
    end
  end

  // ---------------------------------------------------------------------------
  // TX FIFO pointers, count and overflow flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      // A dropped byte outranks a simultaneous clear so the loss is never hidden.
      if (overflow_set) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // RX holding register
  // ---------------------------------------------------------------------------
  // Accept and release are mutually exclusive, because accept needs rx_full=0 and release needs rx_full=1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_full <= 1'b0;
      rx_hold <= 8'h00;
    end else begin
      if (rx_accept) begin
        rx_hold <= bus.rx_data;
        rx_full <= 1'b1;
      end else if (rx_release) begin
        rx_full <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.data_in_bus = data_in_q;
  assign bus.tx_valid    = !fifo_empty;
  assign bus.tx_data     = tx_fifo[rd_ptr];
  assign bus.rx_ready    = !rx_full;

  // ---------------------------------------------------------------------------
  // Sanity check
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (count <= FULL_CNT)
        else $error("tx fifo count exceeds depth");
    end
  end

endmodule

// File: tb/tb_cpu6_bus_responder.sv
// Directed self-checking bench for cpu6_bus_responder.
// Latency: the bench samples 1 time unit after each rising edge and expects read data one clock after the address.
// Backpressure: the bench drives tx_ready and rx_valid directly to exercise full, empty and overflow cases.
module tb_cpu6_bus_responder;

  logic clock;
  logic reset;

  cpu6_bus_responder_if bus ();

  cpu6_bus_responder #(
    .RAM_ADDR_BITS  (12),
    .MMIO_BASE      (16'hF200),
    .FIFO_DEPTH_LOG2(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data);
    bus.address_bus  = addr;
    bus.data_out_bus = data;
    bus.write_en_bus = 1'b1;
    tick();
    bus.write_en_bus = 1'b0;
  endtask

  initial begin
    bus.address_bus  = 16'h0000;
    bus.data_out_bus = 8'h00;
    bus.write_en_bus = 1'b0;
    bus.read_strobe  = 1'b0;
    bus.tx_ready     = 1'b0;
    bus.rx_data      = 8'h00;
    bus.rx_valid     = 1'b0;
    reset            = 1'b1;

    // Reset state
    #2;
    check("rst_data_in", bus.data_in_bus, 8'h00);
    check("rst_tx_valid", {7'b0, bus.tx_valid}, 8'h00);
    check("rst_rx_ready", {7'b0, bus.rx_ready}, 8'h01);
    tick();
    tick();
    reset = 1'b0;

    // 1. RAM write/read, read-first, boundary, unmapped
    cpu_write(16'h0123, 8'hA5);
    tick();
    check("ram_rd_0123", bus.data_in_bus, 8'hA5);
    bus.data_out_bus = 8'h3C;
    bus.write_en_bus = 1'b1;
    tick();
    bus.write_en_bus = 1'b0;
    check("ram_read_first", bus.data_in_bus, 8'hA5);
    tick();
    check("ram_new_byte", bus.data_in_bus, 8'h3C);
    cpu_write(16'h0FFF, 8'h7E);
    tick();
    check("ram_top_byte", bus.data_in_bus, 8'h7E);
    bus.address_bus = 16'h1000;
    tick();
    check("unmapped_1000", bus.data_in_bus, 8'hFF);
    bus.address_bus = 16'h8000;
    tick();
    check("unmapped_8000", bus.data_in_bus, 8'hFF);

    // 2. Three TX bytes held, then drained in order
    bus.tx_ready = 1'b0;
    cpu_write(16'hF201, 8'h41);
    cpu_write(16'hF201, 8'h42);
    cpu_write(16'hF201, 8'h43);
    bus.address_bus = 16'hF200;
    tick();
    check("t2_status", bus.data_in_bus, 8'h02);
    check("t2_tx_valid", {7'b0, bus.tx_valid}, 8'h01);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t2_drain_valid", {7'b0, bus.tx_valid}, 8'h01);
      check("t2_drain_data", bus.tx_data, 8'(8'h41 + i));
      tick();
      check("t2_drain_status", bus.data_in_bus, 8'h02);
    end
    check("t2_empty", {7'b0, bus.tx_valid}, 8'h00);
    bus.tx_ready = 1'b0;

    // 3. Overflow on fifth byte, clear via STATUS write, drain the first four
    for (int i = 0; i < 5; i++) cpu_write(16'hF201, 8'(8'h10 + i));
    bus.address_bus = 16'hF200;
    tick();
    check("t3_status_ovf", bus.data_in_bus, 8'h04);
    cpu_write(16'hF200, 8'hFF);
    check("t3_status_pre_clr", bus.data_in_bus, 8'h04);
    tick();
    check("t3_status_clr", bus.data_in_bus, 8'h00);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t3_drain_data", bus.tx_data, 8'(8'h10 + i));
      tick();
    end
    check("t3_empty", {7'b0, bus.tx_valid}, 8'h00);
    bus.tx_ready = 1'b0;

    // 4. Full FIFO, pop and push in the same cycle. The push is dropped.
    for (int i = 0; i < 4; i++) cpu_write(16'hF201, 8'(8'h20 + i));
    bus.tx_ready = 1'b1;
    cpu_write(16'hF201, 8'h24);
    bus.tx_ready = 1'b0;
    bus.address_bus = 16'hF200;
    tick();
    check("t4_status", bus.data_in_bus, 8'h06);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t4_drain_data", bus.tx_data, 8'(8'h21 + i));
      tick();
    end
    check("t4_empty", {7'b0, bus.tx_valid}, 8'h00);
    bus.tx_ready = 1'b0;
    cpu_write(16'hF200, 8'h00);
    tick();
    check("t4_status_clr", bus.data_in_bus, 8'h02);

    // Push and pop with one entry keep the count. A push while empty only pushes.
    cpu_write(16'hF201, 8'h30);
    bus.tx_ready = 1'b1;
    cpu_write(16'hF201, 8'h31);
    check("pp_valid", {7'b0, bus.tx_valid}, 8'h01);
    check("pp_data", bus.tx_data, 8'h31);
    tick();
    check("pp_empty", {7'b0, bus.tx_valid}, 8'h00);
    cpu_write(16'hF201, 8'h32);
    check("empty_push_valid", {7'b0, bus.tx_valid}, 8'h01);
    check("empty_push_data", bus.tx_data, 8'h32);
    tick();
    check("empty_push_drained", {7'b0, bus.tx_valid}, 8'h00);
    bus.tx_ready = 1'b0;

    // 5. RX holding register
    bus.rx_data  = 8'h5A;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    check("t5_rx_ready_full", {7'b0, bus.rx_ready}, 8'h00);
    bus.rx_data  = 8'h77;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    bus.address_bus = 16'hF200;
    bus.read_strobe = 1'b1;
    tick();
    bus.read_strobe = 1'b0;
    check("t5_status_full", bus.data_in_bus, 8'h03);
    check("t5_strobe_status_noeff", {7'b0, bus.rx_ready}, 8'h00);
    bus.address_bus = 16'hF201;
    bus.read_strobe = 1'b1;
    tick();
    bus.read_strobe = 1'b0;
    check("t5_rx_byte", bus.data_in_bus, 8'h5A);
    check("t5_rx_ready_freed", {7'b0, bus.rx_ready}, 8'h01);
    bus.address_bus = 16'hF200;
    tick();
    check("t5_status_after", bus.data_in_bus, 8'h02);
    bus.address_bus = 16'hF201;
    bus.read_strobe = 1'b1;
    tick();
    bus.read_strobe = 1'b0;
    check("t5_stale_read", bus.data_in_bus, 8'h5A);
    check("t5_stale_rx_ready", {7'b0, bus.rx_ready}, 8'h01);

    // Write and strobe together on DATA push TX and release RX.
    bus.rx_data  = 8'h66;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    bus.read_strobe = 1'b1;
    cpu_write(16'hF201, 8'h55);
    bus.read_strobe = 1'b0;
    check("combo_rx_byte", bus.data_in_bus, 8'h66);
    check("combo_rx_ready", {7'b0, bus.rx_ready}, 8'h01);
    check("combo_tx_data", bus.tx_data, 8'h55);

    // 6. Asynchronous reset mid-transfer while RAM is retained
    cpu_write(16'h0200, 8'h99);
    cpu_write(16'hF201, 8'h56);
    bus.rx_data  = 8'h67;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    bus.address_bus = 16'hF201;
    tick();
    check("t6_pre_rst_data", bus.data_in_bus, 8'h67);
    check("t6_pre_rst_rx_ready", {7'b0, bus.rx_ready}, 8'h00);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_tx_valid", {7'b0, bus.tx_valid}, 8'h00);
    check("t6_rst_rx_ready", {7'b0, bus.rx_ready}, 8'h01);
    check("t6_rst_data_in", bus.data_in_bus, 8'h00);
    #2;
    reset = 1'b0;
    bus.address_bus = 16'h0200;
    tick();
    check("t6_ram_kept", bus.data_in_bus, 8'h99);
    bus.address_bus = 16'hF200;
    tick();
    check("t6_status_post", bus.data_in_bus, 8'h02);
    check("t6_tx_valid_post", {7'b0, bus.tx_valid}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
